vrf_read_port_arbiter: RTL and testbench

Shares one VRF read port among `NUM_REQ` read pipes. Each pipe owns a fixed-depth result FIFO. Grants are round-robin, and the block issues a grant only when the winning pipe has a free result-FIFO credit. It also tracks each in-flight read through the fixed VRF read latency and returns the result data with a one-hot response valid to the requester that issued it. It sits between the per-lane read pipes and the VRF bank read port.

---
 rtl/vrf_read_port_arbiter_if.sv | 47 ++++
 rtl/vrf_read_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_vrf_read_port_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vrf_read_port_arbiter_if.sv
// rtl/vrf_read_port_arbiter_if.sv - request, VRF port and response bundle for vrf_read_port_arbiter
interface vrf_read_port_arbiter_if #(
  parameter int NUM_REQ = 4
);
  // requester side
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [5*NUM_REQ-1:0] req_vs;
  logic [NUM_REQ-1:0]   req_offset;
  logic [2*NUM_REQ-1:0] req_read_source;
  logic [3*NUM_REQ-1:0] req_instruction_index;

  // VRF bank read port
  logic                 vrf_req_valid;
  logic                 vrf_req_ready;
  logic [4:0]           vrf_req_vs;
  logic                 vrf_req_offset;
  logic [1:0]           vrf_req_read_source;
  logic [2:0]           vrf_req_instruction_index;
  logic [31:0]          vrf_read_result;

  // response and credit side
  logic [NUM_REQ-1:0]   resp_valid;
  logic [31:0]          resp_data;
  logic [NUM_REQ-1:0]   credit_return;
  logic                 credit_error;

  // arbiter view
  modport slave (
    input  req_valid, req_vs, req_offset, req_read_source, req_instruction_index,
    input  vrf_req_ready, vrf_read_result, credit_return,
    output req_ready,
    output vrf_req_valid, vrf_req_vs, vrf_req_offset, vrf_req_read_source,
    output vrf_req_instruction_index,
    output resp_valid, resp_data, credit_error
  );

  // read pipes plus VRF bank view
  modport master (
    output req_valid, req_vs, req_offset, req_read_source, req_instruction_index,
    output vrf_req_ready, vrf_read_result, credit_return,
    input  req_ready,
    input  vrf_req_valid, vrf_req_vs, vrf_req_offset, vrf_req_read_source,
    input  vrf_req_instruction_index,
    input  resp_valid, resp_data, credit_error
  );
endinterface

// File: rtl/vrf_read_port_arbiter.sv
// rtl/vrf_read_port_arbiter.sv - credit-gated round-robin VRF read port arbiter (option macro: VRF_ARB_FIXED_PRIO_EN)
module vrf_read_port_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int READ_LATENCY = 2,
  parameter int CREDITS      = 4
) (
  input logic                    clock,
  input logic                    rst_n,
  vrf_read_port_arbiter_if.slave bus
);
  localparam int         PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0] CREDIT_MAX = 3'(CREDITS);

  logic [PTR_W-1:0]   w_rr_ptr;
  logic [2:0]         r_credit [NUM_REQ];
  logic [NUM_REQ-1:0] r_tag    [READ_LATENCY];
  logic               r_credit_error;

  logic [NUM_REQ-1:0] w_eligible;
  logic               w_win_found;
  logic [PTR_W-1:0]   w_win_idx;
  int                 w_scan_idx;
  logic [NUM_REQ-1:0] w_win_onehot;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_fire;
  logic [4:0]         w_vs;
  logic               w_offset;
  logic [1:0]         w_read_source;
  logic [2:0]         w_instruction_index;

  // a requester competes only while its result FIFO still has a free slot
  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_eligible[i] = bus.req_valid[i] && (r_credit[i] != 3'd0);
    end
  end

  // cyclic search from the pointer; scanning offsets high-to-low leaves the nearest eligible index
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_scan_idx  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_scan_idx = int'(w_rr_ptr) + k;
      if (w_scan_idx >= NUM_REQ) begin
        w_scan_idx = w_scan_idx - NUM_REQ;
      end
      if (w_eligible[w_scan_idx[PTR_W-1:0]]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_scan_idx[PTR_W-1:0];
      end
    end
  end

  // steer the winner's fields onto the VRF port
  always_comb begin
    w_win_onehot        = '0;
    w_vs                = '0;
    w_offset            = 1'b0;
    w_read_source       = '0;
    w_instruction_index = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_found && (w_win_idx == PTR_W'(i))) begin
        w_win_onehot[i]     = 1'b1;
        w_vs                = bus.req_vs[5*i +: 5];
        w_offset            = bus.req_offset[i];
        w_read_source       = bus.req_read_source[2*i +: 2];
        w_instruction_index = bus.req_instruction_index[3*i +: 3];
      end
    end
  end

  // grant is zero unless the VRF port accepts, so it doubles as the fire one-hot
  assign w_grant = w_win_onehot & {NUM_REQ{bus.vrf_req_ready}};
  assign w_fire  = w_win_found & bus.vrf_req_ready;

`ifdef VRF_ARB_FIXED_PRIO_EN
  assign w_rr_ptr = '0;
`else
  logic [PTR_W-1:0] r_rr_ptr;

  // step past the winner on each fire so every requester gets its turn
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_fire) begin
      r_rr_ptr <= (int'(w_win_idx) == NUM_REQ - 1) ? '0 : w_win_idx + PTR_W'(1);
    end
  end

  assign w_rr_ptr = r_rr_ptr;
`endif

  // result-FIFO credits: fire takes one, a pop returns one; a return at full credit is an overflow
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_credit[i] <= CREDIT_MAX;
      end
      r_credit_error <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i] && !bus.credit_return[i]) begin
          r_credit[i] <= r_credit[i] - 3'd1;
        end else if (bus.credit_return[i] && !w_grant[i]) begin
          if (r_credit[i] == CREDIT_MAX) begin
            r_credit_error <= 1'b1;
          end else begin
            r_credit[i] <= r_credit[i] + 3'd1;
          end
        end
      end
    end
  end

  // carry each fired requester's one-hot through the fixed read latency
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < READ_LATENCY; j++) begin
        r_tag[j] <= '0;
      end
    end else begin
      r_tag[0] <= w_grant;
      for (int j = 1; j < READ_LATENCY; j++) begin
        r_tag[j] <= r_tag[j-1];
      end
    end
  end

  assign bus.req_ready                 = w_grant;
  assign bus.vrf_req_valid             = w_win_found;
  assign bus.vrf_req_vs                = w_vs;
  assign bus.vrf_req_offset            = w_offset;
  assign bus.vrf_req_read_source       = w_read_source;
  assign bus.vrf_req_instruction_index = w_instruction_index;
  assign bus.resp_valid                = r_tag[READ_LATENCY-1];
  assign bus.resp_data                 = bus.vrf_read_result;
  assign bus.credit_error              = r_credit_error;

endmodule

// File: tb/tb_vrf_read_port_arbiter.sv
// tb/tb_vrf_read_port_arbiter.sv - scoreboard bench for vrf_read_port_arbiter
module tb_vrf_read_port_arbiter;
  localparam int N  = 4;
  localparam int RL = 2;
  localparam int CR = 4;

  typedef struct packed {
    logic [N-1:0] v;
    logic [31:0]  d;
  } exp_t;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  vrf_read_port_arbiter_if #(.NUM_REQ(N)) bus ();

  vrf_read_port_arbiter #(.NUM_REQ(N), .READ_LATENCY(RL), .CREDITS(CR)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [N-1:0] oh(input int w);
    logic [N-1:0] r;
    r = '0;
    r[w] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    bus.vrf_read_result = 32'hA5A5_0000 + cyc;
  endtask

  task automatic push(input int w);
    exp_t e;
    e.v = oh(w);
    e.d = 32'hA5A5_0000 + (cyc + RL);
    sb.push_back(e);
  endtask

  // requester w drives vs=4+w, offset=(w==2), read_source=3-w, instruction_index=w+2
  task automatic check_fields(input int w);
    chk("vrf_req_vs", bus.vrf_req_vs, 32'(4 + w));
    chk("vrf_req_offset", bus.vrf_req_offset, (w == 2) ? 1 : 0);
    chk("vrf_req_read_source", bus.vrf_req_read_source, 32'(3 - w));
    chk("vrf_req_instruction_index", bus.vrf_req_instruction_index, 32'(w + 2));
  endtask

  task automatic grant_cycle(input string name, input int w);
    @(negedge clock);
    chk({name, "_req_ready"}, bus.req_ready, oh(w));
    chk({name, "_vrf_req_valid"}, bus.vrf_req_valid, 1);
    check_fields(w);
    push(w);
    tick();
  endtask

  task automatic idle_cycle(input string name);
    @(negedge clock);
    chk({name, "_req_ready"}, bus.req_ready, 0);
    chk({name, "_vrf_req_valid"}, bus.vrf_req_valid, 0);
    tick();
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.credit_return = '0;
    bus.vrf_req_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // monitor: every response the DUT presents must match the oldest expected read
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.resp_valid !== '0) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL resp_unexpected: got resp_valid %b with no read pending", bus.resp_valid);
        end else begin
          e = sb.pop_front();
          chk("resp_valid", bus.resp_valid, e.v);
          chk("resp_data", bus.resp_data, e.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.req_valid             = '0;
    bus.req_vs                = {5'd7, 5'd6, 5'd5, 5'd4};
    bus.req_offset            = 4'b0100;
    bus.req_read_source       = {2'd0, 2'd1, 2'd2, 2'd3};
    bus.req_instruction_index = {3'd5, 3'd4, 3'd3, 3'd2};
    bus.vrf_req_ready         = 1'b0;
    bus.vrf_read_result       = 32'hA5A5_0000;
    bus.credit_return         = '0;

    // reset state
    @(negedge clock);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_vrf_req_valid", bus.vrf_req_valid, 0);
    chk("rst_credit_error", bus.credit_error, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    bus.req_valid = 4'b0100;
    #1;
    chk("rst_vrf_req_valid_follows", bus.vrf_req_valid, 1);
    chk("rst_req_ready_low", bus.req_ready, 0);
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    bus.req_valid = '0;
    tick();

    // single read from requester 1; response data A5A5_0001 two cycles later
    cyc = -1;
    bus.req_valid = 4'b0010;
    bus.vrf_req_ready = 1'b1;
    grant_cycle("single", 1);
    bus.req_valid = '0;
    idle_cycle("single_after");
    tick();
    bus.credit_return = 4'b0010;
    tick();
    bus.credit_return = '0;
    @(negedge clock);
    chk("single_credit_restored", bus.credit_error, 0);

    // round-robin with a credit return for the previous winner every cycle
    do_reset();
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      bus.credit_return = (k > 0) ? oh((k - 1) % 4) : '0;
      grant_cycle("rr", k % 4);
    end
    bus.req_valid = '0;
    bus.credit_return = oh(1);
    tick();
    bus.credit_return = '0;
    @(negedge clock);
    chk("rr_credit_error", bus.credit_error, 0);

    // credit stall on requester 0, then one return gives one more fire
    do_reset();
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) grant_cycle("stall_fill", 0);
    idle_cycle("stall_blocked0");
    idle_cycle("stall_blocked1");
    bus.credit_return = 4'b0001;
    idle_cycle("stall_return_cycle");
    bus.credit_return = '0;
    grant_cycle("stall_refill", 0);
    idle_cycle("stall_blocked2");
    bus.req_valid = '0;

    // backpressure with requesters 0 and 2
    do_reset();
    bus.req_valid = 4'b0101;
    bus.vrf_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("bp_vrf_req_valid", bus.vrf_req_valid, 1);
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_vrf_req_vs", bus.vrf_req_vs, 4);
      tick();
    end
    bus.vrf_req_ready = 1'b1;
    grant_cycle("bp_first", 0);
    grant_cycle("bp_second", 2);
    bus.req_valid = '0;

    // credit overflow is sticky until reset; reset drops the in-flight read
    do_reset();
    bus.credit_return = 4'b1000;
    tick();
    bus.credit_return = '0;
    @(negedge clock);
    chk("ovf_credit_error_set", bus.credit_error, 1);
    tick();
    tick();
    @(negedge clock);
    chk("ovf_credit_error_sticky", bus.credit_error, 1);
    bus.req_valid = 4'b0010;
    @(negedge clock);
    chk("ovf_fire_req_ready", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '0;
    rst_n = 1'b0;
    @(negedge clock);
    chk("ovf_rst_credit_error", bus.credit_error, 0);
    chk("ovf_rst_resp_valid", bus.resp_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    bus.req_valid = 4'b0010;
    for (int k = 0; k < CR; k++) grant_cycle("ovf_full_credit", 1);
    idle_cycle("ovf_blocked");
    bus.req_valid = '0;

    // requesters 1 and 3 competing: fixed priority always picks 1
    do_reset();
    bus.req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
`ifdef VRF_ARB_FIXED_PRIO_EN
      bus.credit_return = (k > 0) ? oh(1) : '0;
      grant_cycle("prio", 1);
`else
      bus.credit_return = (k > 0) ? oh((k % 2 == 1) ? 1 : 3) : '0;
      grant_cycle("prio", (k % 2 == 1) ? 3 : 1);
`endif
    end
    bus.req_valid = '0;
`ifdef VRF_ARB_FIXED_PRIO_EN
    bus.credit_return = oh(1);
`else
    bus.credit_return = oh(3);
`endif
    tick();
    bus.credit_return = '0;
    repeat (4) tick();
    @(negedge clock);
    chk("final_credit_error", bus.credit_error, 0);
    chk("final_pending_reads", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
